// File: rtl/nibble_deserializer.sv
// ============================================================================
// Module   : nibble_deserializer
// Brief    : Collects NIBBLES consecutive 4-bit nibbles from a shift chain
//            into one parallel word, presented on a valid/ready handshake.
//            While a completed word waits, the nibble side is back-pressured.
// Options  : DESER_FLUSH_EN - adds a 'flush' input that emits a partially
//            filled word, left-aligned with zero padding in the low nibbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_deserializer #(
    parameter int NIBBLES = 8,
    parameter int CW      = $clog2(NIBBLES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           si,
    input  logic                 shn,
    output logic                 shn_rdy,
    output logic [4*NIBBLES-1:0] word,
    output logic                 word_vld,
    input  logic                 word_rdy,
`ifdef DESER_FLUSH_EN
    input  logic                 flush,
`endif
    output logic [CW-1:0]        cnt
);

    localparam int            c_WW   = 4 * NIBBLES;
    localparam logic [CW-1:0] c_ONE  = CW'(1);
    localparam logic [CW-1:0] c_LAST = CW'(NIBBLES - 1);
`ifdef DESER_FLUSH_EN
    localparam logic [CW-1:0] c_NIB  = CW'(NIBBLES);
`endif

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } state_t;

    state_t            r_state;
    logic [c_WW-1:0]   r_word;
    logic [CW-1:0]     r_cnt;

`ifdef DESER_FLUSH_EN
    logic              w_flush_go;
    logic [c_WW-1:0]   w_flush_word;

    // Partial word: drop the stale upper nibbles and left-align the k captured ones
    always_comb begin
        w_flush_go   = flush && (r_cnt != '0);
        w_flush_word = r_word << {(c_NIB - r_cnt), 2'b00};
    end
`endif

    // Accumulator and two-state handshake FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= COLLECT;
            r_word  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                COLLECT: begin
`ifdef DESER_FLUSH_EN
                    // flush wins over a nibble arriving on the same edge
                    if (w_flush_go) begin
                        r_word  <= w_flush_word;
                        r_state <= FULL;
                    end else
`endif
                    if (shn) begin
                        r_word <= {r_word[c_WW-5:0], si};
                        r_cnt  <= r_cnt + c_ONE;
                        if (r_cnt == c_LAST) begin
                            r_state <= FULL;
                        end
                    end
                end
                FULL: begin
                    // word is left in place; it is overwritten by the next shifts
                    if (word_rdy) begin
                        r_state <= COLLECT;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= COLLECT;
                end
            endcase
        end
    end

    assign shn_rdy  = (r_state == COLLECT);
    assign word_vld = (r_state == FULL);
    assign word     = r_word;
    assign cnt      = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nibble_deserializer.sv
// ============================================================================
// Module   : tb_nibble_deserializer
// Brief    : Self-checking bench for nibble_deserializer (NIBBLES = 8).
//            Define DESER_FLUSH_EN for both files to include the flush checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_deserializer;

    localparam int NIBBLES = 8;
    localparam int CW      = $clog2(NIBBLES + 1);

    logic                 clk;
    logic                 rst;
    logic [3:0]           si;
    logic                 shn;
    logic                 shn_rdy;
    logic [4*NIBBLES-1:0] word;
    logic                 word_vld;
    logic                 word_rdy;
    logic [CW-1:0]        cnt;
`ifdef DESER_FLUSH_EN
    logic                 flush;
`endif

    nibble_deserializer #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .si       (si),
        .shn      (shn),
        .shn_rdy  (shn_rdy),
        .word     (word),
        .word_vld (word_vld),
        .word_rdy (word_rdy),
`ifdef DESER_FLUSH_EN
        .flush    (flush),
`endif
        .cnt      (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        shn;
        logic [3:0]  si;
        logic        rdy;
        logic [31:0] exp_word;
        logic        exp_vld;
        logic        exp_srdy;
        int          exp_cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ew, input logic ev,
                             input logic er, input int ec);
        check({tag, " word"},     word,            ew);
        check({tag, " word_vld"}, {31'b0, word_vld}, {31'b0, ev});
        check({tag, " shn_rdy"},  {31'b0, shn_rdy},  {31'b0, er});
        check({tag, " cnt"},      32'(cnt),        32'(ec));
    endtask

    task automatic add(input logic s, input logic [3:0] d, input logic r,
                       input logic [31:0] ew, input logic ev, input logic er, input int ec);
        vec_t v;
        v.shn = s; v.si = d; v.rdy = r;
        v.exp_word = ew; v.exp_vld = ev; v.exp_srdy = er; v.exp_cnt = ec;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs after the falling edge, sample 1 time unit after the rising edge
    task automatic cycle(input logic s, input logic [3:0] d, input logic r);
        @(negedge clk);
        shn = s; si = d; word_rdy = r;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [31:0] exp_words [3];
        int          idx;
        int          nwords;
        int          low_rdy;
        int          vld_edge [3];

        rst = 1'b0; si = '0; shn = 1'b0; word_rdy = 1'b0;
`ifdef DESER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 1'b0, 1'b1, 0);
        @(negedge clk);
        rst = 1'b1;

        // ---- table: fill 1..8, hold under ignored shn, take, refill 9..2 ----
        add(1, 4'h1, 0, 32'h00000001, 0, 1, 1);
        add(1, 4'h2, 0, 32'h00000012, 0, 1, 2);
        add(1, 4'h3, 0, 32'h00000123, 0, 1, 3);
        add(1, 4'h4, 0, 32'h00001234, 0, 1, 4);
        add(1, 4'h5, 0, 32'h00012345, 0, 1, 5);
        add(1, 4'h6, 0, 32'h00123456, 0, 1, 6);
        add(1, 4'h7, 0, 32'h01234567, 0, 1, 7);
        add(1, 4'h8, 0, 32'h12345678, 1, 0, 8);
        add(1, 4'hF, 0, 32'h12345678, 1, 0, 8);
        add(1, 4'hF, 0, 32'h12345678, 1, 0, 8);
        add(1, 4'hF, 0, 32'h12345678, 1, 0, 8);
        add(1, 4'hF, 1, 32'h12345678, 0, 1, 0);   // take; same-edge nibble refused
        add(0, 4'hF, 1, 32'h12345678, 0, 1, 0);   // word_rdy with no word: no effect
        add(0, 4'hF, 0, 32'h12345678, 0, 1, 0);   // gap: hold
        add(1, 4'h9, 0, 32'h23456789, 0, 1, 1);
        add(1, 4'h8, 0, 32'h34567898, 0, 1, 2);
        add(1, 4'h7, 0, 32'h45678987, 0, 1, 3);
        add(1, 4'h6, 0, 32'h56789876, 0, 1, 4);
        add(1, 4'h5, 0, 32'h67898765, 0, 1, 5);
        add(1, 4'h4, 0, 32'h78987654, 0, 1, 6);
        add(1, 4'h3, 0, 32'h89876543, 0, 1, 7);
        add(1, 4'h2, 0, 32'h98765432, 1, 0, 8);

        foreach (vecs[i]) begin
            cycle(vecs[i].shn, vecs[i].si, vecs[i].rdy);
            check_all($sformatf("vec%0d", i), vecs[i].exp_word, vecs[i].exp_vld,
                      vecs[i].exp_srdy, vecs[i].exp_cnt);
        end

        // ---- continuous stream: nibble k = (10+k) mod 16, word_rdy held high ----
        cycle(0, 4'h0, 1);
        check_all("drain", 32'h98765432, 0, 1, 0);
        exp_words[0] = 32'hABCDEF01;
        exp_words[1] = 32'h23456789;
        exp_words[2] = 32'hABCDEF01;
        idx = 0; nwords = 0; low_rdy = 0;
        for (int c = 1; c <= 27; c++) begin
            logic acc;
            @(negedge clk);
            shn = 1'b1; word_rdy = 1'b1;
            si  = 4'((10 + idx) % 16);
            acc = shn_rdy;
            if (!shn_rdy) low_rdy++;
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (word_vld) begin
                if (nwords < 3) begin
                    check($sformatf("stream word%0d", nwords), word, exp_words[nwords]);
                    vld_edge[nwords] = c;
                end
                nwords++;
            end
        end
        check("stream word count", 32'(nwords), 32'd3);
        check("stream shn_rdy low cycles", 32'(low_rdy), 32'd3);
        if (nwords >= 3) begin
            check("stream first vld edge", 32'(vld_edge[0]), 32'd8);
            check("stream word period a", 32'(vld_edge[1] - vld_edge[0]), 32'd9);
            check("stream word period b", 32'(vld_edge[2] - vld_edge[1]), 32'd9);
        end

        // ---- gapped partial word, then asynchronous reset between edges ----
        cycle(1, 4'h9, 0);
        cycle(0, 4'h0, 0);
        cycle(0, 4'h0, 0);
        cycle(1, 4'h8, 0);
        cycle(0, 4'h0, 0);
        cycle(0, 4'h0, 0);
        cycle(1, 4'h7, 0);
        check_all("gapped", 32'hDEF01987, 0, 1, 3);
        shn = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all("async reset", 32'h0, 0, 1, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 8; k++) cycle(1, 4'(k), 0);
        check_all("after reset", 32'h01234567, 1, 0, 8);

`ifdef DESER_FLUSH_EN
        // ---- flush of a partial word; flush with empty accumulator ----
        cycle(0, 4'h0, 1);
        cycle(1, 4'h3, 0);
        cycle(1, 4'hC, 0);
        cycle(1, 4'h5, 0);
        @(negedge clk);
        shn = 1'b1; si = 4'h9; word_rdy = 1'b0; flush = 1'b1;
        @(posedge clk);
        #1;
        check_all("flush partial", 32'h3C500000, 1, 0, 3);
        @(negedge clk);
        flush = 1'b0;
        cycle(0, 4'h0, 1);
        check_all("flush take", 32'h3C500000, 0, 1, 0);
        @(negedge clk);
        flush = 1'b1;
        cycle(0, 4'h0, 0);
        check_all("flush empty", 32'h3C500000, 0, 1, 0);
        @(negedge clk);
        flush = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_deserializer.md
Name: nibble_deserializer

Overview:
Reader end of the 4-bit nibble shift path: collects the nibble stream that a shift chain emits under its shift strobe and assembles NIBBLES consecutive nibbles into one parallel word. The word is presented with a valid/ready handshake. While a completed word waits to be taken, the block back-pressures the nibble side. It sits between the nibble delay line and any word-wide consumer.

Parameters:
NIBBLES, 8, nibbles per assembled word (>=2); word width = 4*NIBBLES
CW, $clog2(NIBBLES+1), width of the nibble counter / cnt port (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (0 = reset)
si  input  4  incoming nibble
shn  input  1  nibble strobe; nibble accepted on an edge where shn & shn_rdy
shn_rdy  output  1  block can accept a nibble this cycle
word  output  4*NIBBLES  assembled word, valid while word_vld=1
word_vld  output  1  word holds a complete (or flushed) word
word_rdy  input  1  consumer takes word on an edge where word_vld & word_rdy
cnt  output  CW  nibbles currently held in the accumulator (0..NIBBLES)

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately without waiting for clk): word=0, word_vld=0, cnt=0, state=COLLECT, shn_rdy=1. Reset mid-word discards partial data. Reset while word_vld=1 drops the word.
- FSM has 2 states. shn_rdy = (state==COLLECT). word_vld = (state==FULL). Both are decoded directly from the state register.
- COLLECT, on an accepted nibble:
  - word <= {word[4*NIBBLES-5:0], si}: left shift, the new nibble enters the LSBs, so the first nibble ends up in the MSBs.
  - cnt <= cnt+1.
  - If cnt==NIBBLES-1 before the edge, next state is FULL and cnt becomes NIBBLES.
- COLLECT with shn=0: everything holds. Gaps between nibbles are allowed and of any length.
- FULL:
  - word and cnt are held stable.
  - shn is ignored; shn_rdy=0, so no nibble is lost if the source obeys shn_rdy.
  - On word_vld & word_rdy: next state COLLECT, cnt=0. word keeps its old value until overwritten by the next shifts.
- Same edge as word take: a shn at the edge where the word is taken is NOT accepted, because shn_rdy is still 0. The first new nibble is accepted on the following cycle.
- Latency: word_vld rises on the same clock edge that accepts the NIBBLES-th nibble. Minimum word period is NIBBLES+1 cycles under continuous shn and word_rdy.
- word_rdy while word_vld=0 has no effect.

Optional Feature:
Macro DESER_FLUSH_EN adds port flush (input, 1 bit).
- With the macro, in COLLECT with flush=1 and cnt>0:
  - The next state is FULL, cnt keeps the partial count k.
  - word is left-aligned: the captured nibbles move to the MSBs and the low (NIBBLES-k) nibbles are 0.
  - flush has priority over a shn on the same edge; that nibble is not accepted.
- flush with cnt==0, or in FULL, is ignored.
- Without the macro: no flush port, and the block only ever emits full words.

Test Plan:
- Reset then 8 consecutive nibbles 1,2,…,8 with word_rdy=0 → word_vld=1 on the 8th edge, word=0x12345678, cnt=8, shn_rdy=0.
- From that FULL state, drive shn=1 with si=F for 3 cycles, then pulse word_rdy → word stays 0x12345678 throughout; after the take, cnt=0 and none of the F nibbles appear in the next word.
- Continuous shn and word_rdy with nibbles A,B,C,… → one word per 9 cycles; shn_rdy low exactly 1 cycle per word; words 0xABCDEF01, …
- Nibbles 9,8,7 with 2-cycle gaps between them, then assert rst=0 asynchronously between clock edges → outputs go to reset values immediately. The next 8 nibbles 0..7 give word=0x01234567.
- With DESER_FLUSH_EN, feed nibbles 3,C,5 then flush=1 (shn=1 on the same edge) → word_vld=1, word=0x3C500000, cnt=3.
- With DESER_FLUSH_EN, flush=1 with cnt=0 → no state change, word_vld stays 0.
